red_pitaya_hk_arb: RTL and testbench

Two-master round-robin arbiter for the house-keeping register bus. Master 0 is the PS system-bus bridge; master 1 is a fabric-side requester such as an LED or expansion-connector sequencer. The block latches single-cycle read and write strobes from both masters and issues them one at a time to the house-keeping slave. It waits for the slave ack, with a timeout, and returns the response to the originating master only.

---
 rtl/red_pitaya_hk_arb.sv | 186 ++++++++++++++++++
 tb/tb_red_pitaya_hk_arb.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/red_pitaya_hk_arb.sv
// Two-master round-robin arbiter for the house-keeping register bus.
// Each master owns a one-deep capture slot; one transaction is in flight at a time.
module red_pitaya_hk_arb #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  input  logic [3:0]  m0_sel_i,
  input  logic        m0_wen_i,
  input  logic        m0_ren_i,
  output logic [31:0] m0_rdata_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  input  logic [3:0]  m1_sel_i,
  input  logic        m1_wen_i,
  input  logic        m1_ren_i,
  output logic [31:0] m1_rdata_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] s_addr_o,
  output logic [31:0] s_wdata_o,
  output logic [3:0]  s_sel_o,
  output logic        s_wen_o,
  output logic        s_ren_o,
  input  logic [31:0] s_rdata_i,
  input  logic        s_ack_i,
  input  logic        s_err_i
);

  localparam int unsigned CW = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t          r_state;
  logic            r_v0;
  logic            r_we0;
  logic [31:0]     r_addr0;
  logic [31:0]     r_wdata0;
  logic [3:0]      r_sel0;
  logic            r_v1;
  logic            r_we1;
  logic [31:0]     r_addr1;
  logic [31:0]     r_wdata1;
  logic [3:0]      r_sel1;
  logic            r_last;
  logic            r_win;
  logic [CW-1:0]   r_cnt;

  logic            w_pick;
  logic            w_we;
  logic [31:0]     w_addr;
  logic [31:0]     w_wdata;
  logic [3:0]      w_sel;
  logic            w_clr0;
  logic            w_clr1;
  logic            w_timeout;
  logic            w_done;

  // On a tie the master that did not win last time is chosen.
  assign w_pick    = (r_v0 && r_v1) ? ~r_last : r_v1;
  assign w_we      = w_pick ? r_we1    : r_we0;
  assign w_addr    = w_pick ? r_addr1  : r_addr0;
  assign w_wdata   = w_pick ? r_wdata1 : r_wdata0;
  assign w_sel     = w_pick ? r_sel1   : r_sel0;
  assign w_clr0    = (r_state == ST_RESP) && !r_win;
  assign w_clr1    = (r_state == ST_RESP) &&  r_win;
  assign w_timeout = (r_state == ST_WAIT) && (r_cnt == CW'(TIMEOUT));
  assign w_done    = s_ack_i || w_timeout;

  // Master 0 capture slot; strobes landing on an occupied slot are dropped.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_v0     <= 1'b0;
      r_we0    <= 1'b0;
      r_addr0  <= '0;
      r_wdata0 <= '0;
      r_sel0   <= '0;
    end else if (w_clr0) begin
      r_v0 <= 1'b0;
    end else if (!r_v0 && (m0_wen_i || m0_ren_i)) begin
      r_v0     <= 1'b1;
      r_we0    <= m0_wen_i;
      r_addr0  <= m0_addr_i;
      r_wdata0 <= m0_wdata_i;
      r_sel0   <= m0_sel_i;
    end
  end

  // Master 1 capture slot.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_v1     <= 1'b0;
      r_we1    <= 1'b0;
      r_addr1  <= '0;
      r_wdata1 <= '0;
      r_sel1   <= '0;
    end else if (w_clr1) begin
      r_v1 <= 1'b0;
    end else if (!r_v1 && (m1_wen_i || m1_ren_i)) begin
      r_v1     <= 1'b1;
      r_we1    <= m1_wen_i;
      r_addr1  <= m1_addr_i;
      r_wdata1 <= m1_wdata_i;
      r_sel1   <= m1_sel_i;
    end
  end

  // Grant / issue / wait / respond sequencer with registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= ST_IDLE;
      r_last     <= 1'b1;
      r_win      <= 1'b0;
      r_cnt      <= '0;
      s_addr_o   <= '0;
      s_wdata_o  <= '0;
      s_sel_o    <= '0;
      s_wen_o    <= 1'b0;
      s_ren_o    <= 1'b0;
      m0_ack_o   <= 1'b0;
      m0_err_o   <= 1'b0;
      m0_rdata_o <= '0;
      m1_ack_o   <= 1'b0;
      m1_err_o   <= 1'b0;
      m1_rdata_o <= '0;
    end else begin
      s_wen_o    <= 1'b0;
      s_ren_o    <= 1'b0;
      m0_ack_o   <= 1'b0;
      m0_err_o   <= 1'b0;
      m0_rdata_o <= '0;
      m1_ack_o   <= 1'b0;
      m1_err_o   <= 1'b0;
      m1_rdata_o <= '0;
      case (r_state)
        ST_IDLE: begin
          if (r_v0 || r_v1) begin
            r_win     <= w_pick;
            r_last    <= w_pick;
            r_cnt     <= '0;
            s_addr_o  <= w_addr;
            s_wdata_o <= w_wdata;
            s_sel_o   <= w_sel;
            s_wen_o   <= w_we;
            s_ren_o   <= !w_we;
            r_state   <= ST_ISSUE;
          end
        end
        ST_ISSUE, ST_WAIT: begin
          // A real ack takes priority over a timeout in the same cycle.
          if (w_done) begin
            r_state <= ST_RESP;
            if (r_win) begin
              m1_ack_o   <= 1'b1;
              m1_rdata_o <= s_ack_i ? s_rdata_i : 32'd0;
              m1_err_o   <= s_ack_i ? s_err_i   : 1'b1;
            end else begin
              m0_ack_o   <= 1'b1;
              m0_rdata_o <= s_ack_i ? s_rdata_i : 32'd0;
              m0_err_o   <= s_ack_i ? s_err_i   : 1'b1;
            end
          end else begin
            r_cnt   <= r_cnt + CW'(1);
            r_state <= ST_WAIT;
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_red_pitaya_hk_arb.sv
// Randomized bench for red_pitaya_hk_arb against a transaction-level arbitration model.
// The model tracks pending requests and derives issue/response cycles from latency rules.
module tb_red_pitaya_hk_arb;

  localparam int unsigned T = 16;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] m0_addr_i, m0_wdata_i, m1_addr_i, m1_wdata_i;
  logic [3:0]  m0_sel_i, m1_sel_i;
  logic        m0_wen_i, m0_ren_i, m1_wen_i, m1_ren_i;
  logic [31:0] m0_rdata_o, m1_rdata_o;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic [31:0] s_addr_o, s_wdata_o, s_rdata_i;
  logic [3:0]  s_sel_o;
  logic        s_wen_o, s_ren_o, s_ack_i, s_err_i;

  always #5 clk_i = ~clk_i;

  red_pitaya_hk_arb #(.TIMEOUT(T)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i), .m0_sel_i(m0_sel_i),
    .m0_wen_i(m0_wen_i), .m0_ren_i(m0_ren_i),
    .m0_rdata_o(m0_rdata_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i), .m1_sel_i(m1_sel_i),
    .m1_wen_i(m1_wen_i), .m1_ren_i(m1_ren_i),
    .m1_rdata_o(m1_rdata_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o), .s_sel_o(s_sel_o),
    .s_wen_o(s_wen_o), .s_ren_o(s_ren_o),
    .s_rdata_i(s_rdata_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i)
  );

  int n_run  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Reference model: pending request per master plus the one transaction in flight.
  logic [1:0]  pv;
  logic        pwe [2];
  logic [31:0] pa [2];
  logic [31:0] pd [2];
  logic [3:0]  ps [2];
  logic        busy;
  logic        last;
  int          own, issue, resp, lat;
  logic [31:0] sl_rdata;
  logic        sl_err;
  int          prob [2];
  int          force_lat;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_m0_ack"},   32'(m0_ack_o),  32'd0);
    check({tag, "_m1_ack"},   32'(m1_ack_o),  32'd0);
    check({tag, "_m0_err"},   32'(m0_err_o),  32'd0);
    check({tag, "_m1_err"},   32'(m1_err_o),  32'd0);
    check({tag, "_m0_rdata"}, m0_rdata_o,     32'd0);
    check({tag, "_m1_rdata"}, m1_rdata_o,     32'd0);
    check({tag, "_s_wen"},    32'(s_wen_o),   32'd0);
    check({tag, "_s_ren"},    32'(s_ren_o),   32'd0);
    check({tag, "_s_addr"},   s_addr_o,       32'd0);
    check({tag, "_s_wdata"},  s_wdata_o,      32'd0);
    check({tag, "_s_sel"},    32'(s_sel_o),   32'd0);
  endtask

  function automatic int pick_lat();
    int r;
    if (force_lat >= 0) return force_lat;
    r = int'($urandom_range(0, 99));
    if (r < 40) return 0;
    if (r < 80) return int'($urandom_range(1, 6));
    if (r < 88) return int'(T);
    return int'(T) + 1 + int'($urandom_range(0, 3));
  endfunction

  task automatic model_reset();
    pv    = 2'b00;
    busy  = 1'b0;
    last  = 1'b1;
    own   = 0;
    issue = 0;
    resp  = 0;
    lat   = 0;
  endtask

  task automatic drive_idle();
    m0_wen_i = 1'b0; m0_ren_i = 1'b0; m1_wen_i = 1'b0; m1_ren_i = 1'b0;
    m0_addr_i = '0; m0_wdata_i = '0; m0_sel_i = '0;
    m1_addr_i = '0; m1_wdata_i = '0; m1_sel_i = '0;
    s_ack_i = 1'b0; s_err_i = 1'b0; s_rdata_i = '0;
  endtask

  // One clock cycle: model decision, stimulus, then checks at the falling edge.
  // op codes: 0 none/random, 1 read, 2 write, 3 read+write.
  task automatic step(input int f0 = 0, input int f1 = 0);
    logic        wen [2];
    logic        ren [2];
    logic [31:0] a [2];
    logic [31:0] d [2];
    logic [3:0]  s [2];
    int          op;
    logic        exp_ack0, exp_ack1, in_xfer;
    @(posedge clk_i);
    cyc++;
    #1;
    if (!busy && pv != 2'b00) begin
      own      = (pv == 2'b11) ? (last ? 0 : 1) : (pv[1] ? 1 : 0);
      last     = (own == 1);
      busy     = 1'b1;
      issue    = cyc + 1;
      lat      = pick_lat();
      resp     = (lat <= int'(T)) ? cyc + 2 + lat : cyc + 2 + int'(T);
      sl_rdata = $urandom;
      sl_err   = 1'($urandom_range(0, 1));
    end
    in_xfer   = busy && (cyc >= issue) && (cyc < resp);
    s_rdata_i = $urandom;
    s_err_i   = 1'($urandom_range(0, 1));
    s_ack_i   = 1'b0;
    if (busy && lat <= int'(T) && cyc == issue + lat) begin
      s_ack_i   = 1'b1;
      s_rdata_i = sl_rdata;
      s_err_i   = sl_err;
    end else if (!in_xfer) begin
      s_ack_i = ($urandom_range(0, 3) == 0);
    end
    for (int m = 0; m < 2; m++) begin
      op = (m == 0) ? f0 : f1;
      if (op == 0 && int'($urandom_range(0, 99)) < prob[m]) op = int'($urandom_range(1, 3));
      a[m]   = $urandom;
      d[m]   = $urandom;
      s[m]   = 4'($urandom);
      wen[m] = (op == 2) || (op == 3);
      ren[m] = (op == 1) || (op == 3);
      if (op != 0 && !pv[m]) begin
        pv[m]  = 1'b1;
        pwe[m] = wen[m];
        pa[m]  = a[m];
        pd[m]  = d[m];
        ps[m]  = s[m];
      end
    end
    m0_addr_i = a[0]; m0_wdata_i = d[0]; m0_sel_i = s[0]; m0_wen_i = wen[0]; m0_ren_i = ren[0];
    m1_addr_i = a[1]; m1_wdata_i = d[1]; m1_sel_i = s[1]; m1_wen_i = wen[1]; m1_ren_i = ren[1];
    @(negedge clk_i);
    check("s_wen", 32'(s_wen_o), 32'(busy && cyc == issue &&  pwe[own]));
    check("s_ren", 32'(s_ren_o), 32'(busy && cyc == issue && !pwe[own]));
    if (busy && cyc >= issue) begin
      check("s_addr",  s_addr_o,      pa[own]);
      check("s_wdata", s_wdata_o,     pd[own]);
      check("s_sel",   32'(s_sel_o),  32'(ps[own]));
    end
    exp_ack0 = busy && cyc == resp && own == 0;
    exp_ack1 = busy && cyc == resp && own == 1;
    check("m0_ack", 32'(m0_ack_o), 32'(exp_ack0));
    check("m1_ack", 32'(m1_ack_o), 32'(exp_ack1));
    if (exp_ack0) begin
      check("m0_rdata", m0_rdata_o,    (lat <= int'(T)) ? sl_rdata : 32'd0);
      check("m0_err",   32'(m0_err_o), (lat <= int'(T)) ? 32'(sl_err) : 32'd1);
    end
    if (exp_ack1) begin
      check("m1_rdata", m1_rdata_o,    (lat <= int'(T)) ? sl_rdata : 32'd0);
      check("m1_err",   32'(m1_err_o), (lat <= int'(T)) ? 32'(sl_err) : 32'd1);
    end
    if (busy && cyc == resp) begin
      pv[own] = 1'b0;
      busy    = 1'b0;
    end
  endtask

  task automatic drain();
    prob[0] = 0;
    prob[1] = 0;
    for (int i = 0; i < 100 && (busy || pv != 2'b00); i++) step();
  endtask

  // Reset in the middle of a long wait, then a fresh m1 read.
  task automatic reset_mid();
    drain();
    force_lat = int'(T) + 5;
    step(1, 0);
    repeat (5) step();
    force_lat = -1;
    rst_i = 1'b1;
    #1;
    check_all_zero("rst_mid");
    drive_idle();
    repeat (3) begin
      @(posedge clk_i);
      cyc++;
      @(negedge clk_i);
      check("rst_m0_ack", 32'(m0_ack_o), 32'd0);
      check("rst_m1_ack", 32'(m1_ack_o), 32'd0);
      check("rst_s_en",   32'({s_wen_o, s_ren_o}), 32'd0);
    end
    rst_i = 1'b0;
    model_reset();
    force_lat = 0;
    step(0, 1);
    repeat (5) step();
    force_lat = -1;
  endtask

  initial begin
    rst_i     = 1'b1;
    force_lat = -1;
    prob[0]   = 0;
    prob[1]   = 0;
    drive_idle();
    model_reset();
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check_all_zero("reset");
    rst_i = 1'b0;

    // Simultaneous writes right after reset: m0 first, m1 three cycles later.
    force_lat = 0;
    step(2, 2);
    repeat (10) step();
    step(1, 0);
    repeat (6) step();
    force_lat = -1;

    prob[0] = 30;  prob[1] = 30;
    repeat (400) step();
    prob[0] = 100; prob[1] = 100;
    repeat (300) step();
    prob[0] = 10;  prob[1] = 60;
    repeat (300) step();
    drain();

    // Slave never answers: timeout error, then a normal transaction.
    force_lat = int'(T) + 1;
    step(0, 1);
    repeat (22) step();
    force_lat = -1;
    step(0, 1);
    repeat (25) step();

    reset_mid();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
